// File: rtl/regblock_seq_if.sv
// Bundles every signal between the instruction sequencer, its instruction source,
// the ALU and the register block. master = sequencer side, slave = environment side.
interface regblock_seq_if #(
    parameter int RWIDTH = 6,
    parameter int DWIDTH = 32,
    parameter int IMM_IN = 15,
    parameter int CNT_W  = 16
);

    // instruction handshake
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;

    // ALU control
    logic              alu_start;
    logic [3:0]        alu_fn;
    logic              alu_done;
    logic [DWIDTH-1:0] alu_result;

    // register block control
    logic [RWIDTH-1:0] rs;
    logic [RWIDTH-1:0] rt;
    logic [RWIDTH-1:0] rd;
    logic [DWIDTH-1:0] wd;
    logic              we;
    logic              mux_sel;
    logic [IMM_IN-1:0] imm_in;

    // status
    logic              done;
    logic              busy;
    logic [CNT_W-1:0]  retired;

    modport master (
        input  instr_valid, instr, alu_done, alu_result,
        output instr_ready, alu_start, alu_fn, rs, rt, rd, wd, we,
               mux_sel, imm_in, done, busy, retired
    );

    modport slave (
        output instr_valid, instr, alu_done, alu_result,
        input  instr_ready, alu_start, alu_fn, rs, rt, rd, wd, we,
               mux_sel, imm_in, done, busy, retired
    );

endinterface

// File: rtl/regblock_seq.sv
// Multi-cycle sequencer: accepts one instruction, starts the ALU, waits for its result
// and commits it through the register file. Option: REGBLOCK_SEQ_R0_PROTECT_EN.
module regblock_seq #(
    parameter int RWIDTH = 6,
    parameter int DWIDTH = 32,
    parameter int IMM_IN = 15,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    regblock_seq_if.master bus
);

`ifdef REGBLOCK_SEQ_R0_PROTECT_EN
    localparam bit R0_PROTECT = 1'b1;
`else
    localparam bit R0_PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        CLS_R   = 2'b00,
        CLS_I   = 2'b01,
        CLS_NOP = 2'b10,
        CLS_NWB = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB,
        ST_DONE
    } state_e;

    state_e            state;
    logic [31:0]       instr_q;
    logic [DWIDTH-1:0] wd_q;
    logic [CNT_W-1:0]  retired_q;
    logic              ready_q;
    logic              start_q;
    logic              we_q;
    logic              done_q;
    logic              busy_q;

    cls_e              cls;
    logic              uses_rt;
    logic              rd_is_r0;

    assign cls      = cls_e'(instr_q[31:30]);
    assign uses_rt  = (cls == CLS_R) || (cls == CLS_NWB);
    assign rd_is_r0 = (instr_q[29:24] == 6'd0);

    // Decoded fields come straight from the latched word, so they stay stable
    // from ISSUE until the sequencer returns to IDLE.
    assign bus.rd      = instr_q[29:24];
    assign bus.rs      = instr_q[23:18];
    assign bus.rt      = uses_rt ? instr_q[17:12] : '0;
    assign bus.imm_in  = instr_q[17:3];
    assign bus.mux_sel = (cls == CLS_I);
    assign bus.alu_fn  = uses_rt ? instr_q[3:0] : 4'h0;

    assign bus.instr_ready = ready_q;
    assign bus.alu_start   = start_q;
    assign bus.we          = we_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.wd          = wd_q;
    assign bus.retired     = retired_q;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // flop samples the pre-edge values; the asynchronous reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            instr_q   <= '0;
            wd_q      <= '0;
            retired_q <= '0;
            ready_q   <= 1'b1;
            start_q   <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (cls_e'(bus.instr[31:30]) == CLS_NOP) begin
                            state     <= ST_DONE;
                            done_q    <= 1'b1;
                            retired_q <= retired_q + CNT_W'(1);
                        end else begin
                            state   <= ST_ISSUE;
                            start_q <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.alu_done) begin
                        wd_q      <= bus.alu_result;
                        done_q    <= 1'b1;
                        retired_q <= retired_q + CNT_W'(1);
                        // A protected write to register 0 completes without a write pulse.
                        if ((cls == CLS_NWB) || (R0_PROTECT && rd_is_r0)) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WB;
                            we_q  <= 1'b1;
                        end
                    end
                end

                ST_WB, ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
